exp_arbiter: RTL and testbench

EXP_ARBITER -- requirements
Module: exp_arbiter

---
 rtl/exp_arbiter.sv | 143 ++++++++++++++
 tb/tb_exp_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_arbiter.sv
// Round-robin share of one exp unit by two requesters; response at least 3 cycles after accept, held until rspN_ready.
// No new operand is accepted while a transaction is open. Define EXP_ARB_TIMEOUT_EN for a WAIT timeout with sticky err.
module exp_arbiter #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [9:0] req0_x,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [9:0] req1_x,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic [9:0] rsp0_data,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  output logic [9:0] rsp1_data,
  input  logic       rsp1_ready,
  output logic [9:0] exp_x,
  output logic       exp_start,
  input  logic [9:0] exp_result,
  input  logic       exp_done,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       pick;
  logic [9:0] exp_x_q, exp_x_d;
  logic [9:0] rsp_data_q, rsp_data_d;

`ifdef EXP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // On a tie the port not granted last wins; a lone requester always wins.
  assign pick = (req0_valid & req1_valid) ? ~last_q : req1_valid;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    exp_x_d    = exp_x_q;
    rsp_data_d = rsp_data_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    exp_start  = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
`ifdef EXP_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!reset && (req0_valid || req1_valid)) begin
          req0_ready = ~pick;
          req1_ready = pick;
          grant_d    = pick;
          exp_x_d    = pick ? req1_x : req0_x;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        exp_start = 1'b1;
        state_d   = WAIT;
`ifdef EXP_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      WAIT: begin
        if (exp_done) begin
          rsp_data_d = exp_result;
          state_d    = RESP;
        end
`ifdef EXP_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = 10'h3FF;
          err_d      = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
        if (grant_q ? rsp1_ready : rsp0_ready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      exp_x_q    <= 10'h000;
      rsp_data_q <= 10'h000;
`ifdef EXP_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      exp_x_q    <= exp_x_d;
      rsp_data_q <= rsp_data_d;
`ifdef EXP_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign exp_x     = exp_x_q;
  assign rsp0_data = rsp0_valid ? rsp_data_q : 10'h000;
  assign rsp1_data = rsp1_valid ? rsp_data_q : 10'h000;
`ifdef EXP_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_exp_arbiter.sv
// Bench for exp_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_exp_arbiter;
  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [9:0] req0_x = 10'h000, req1_x = 10'h000;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [9:0] rsp0_data, rsp1_data;
  logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [9:0] exp_x;
  logic       exp_start;
  logic [9:0] exp_result = 10'h000;
  logic       exp_done = 1'b0;
  logic       busy, err;

  exp_arbiter dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .exp_x(exp_x), .exp_start(exp_start), .exp_result(exp_result), .exp_done(exp_done),
    .busy(busy), .err(err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Exp unit stub: answers stub_lat cycles after the start pulse (0 = never); spur injects a stray done.
  int         stub_lat = 1;
  logic [9:0] stub_val = 10'h000;
  bit         spur = 1'b0;
  int         pend = 0;
  always @(posedge CLOCK_50) begin
    logic s;
    s = exp_start;
    #1;
    exp_done = 1'b0;
    if (spur) begin
      exp_done   = 1'b1;
      exp_result = 10'h155;
      spur       = 1'b0;
    end
    if (s) pend = stub_lat;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        exp_done   = 1'b1;
        exp_result = stub_val;
      end
    end
  end

  // Model: an open transaction (port, operand) moves through start / await result / hand back.
  bit         m_busy = 1'b0, m_port = 1'b0, m_last = 1'b1, m_err = 1'b0;
  int         m_stage = 0;
  int         m_wait = 0;
  logic [9:0] m_x = 10'h000, m_data = 10'h000;

  always @(negedge CLOCK_50) begin
    bit pick, any;
    bit er0, er1, ev0, ev1, es;
    logic [9:0] ed0, ed1;
    logic [36:0] e, a;
    if (reset) begin
      m_busy = 1'b0; m_last = 1'b1; m_err = 1'b0; m_x = 10'h000; m_data = 10'h000;
    end
    any  = req0_valid | req1_valid;
    pick = (req0_valid && req1_valid) ? !m_last : req1_valid;
    er0 = 0; er1 = 0; ev0 = 0; ev1 = 0; es = 0; ed0 = 10'h000; ed1 = 10'h000;
    if (!reset && !m_busy && any) begin
      er0 = !pick;
      er1 = pick;
    end
    if (m_busy && m_stage == 0) es = 1'b1;
    if (m_busy && m_stage == 2) begin
      if (m_port) begin ev1 = 1'b1; ed1 = m_data; end
      else begin ev0 = 1'b1; ed0 = m_data; end
    end
    e = {er0, er1, ev0, ev1, ed0, ed1, m_x, es, m_busy, m_err};
    a = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, exp_x, exp_start, busy, err};
    check("cycle_model", 64'(a), 64'(e));
    if (!reset) begin
      if (!m_busy) begin
        if (any) begin
          m_busy = 1'b1; m_port = pick; m_x = pick ? req1_x : req0_x; m_stage = 0;
        end
      end else begin
        case (m_stage)
          0: begin m_stage = 1; m_wait = 0; end
          1: if (exp_done) begin
               m_data = exp_result; m_stage = 2;
             end
`ifdef EXP_ARB_TIMEOUT_EN
             else begin
               m_wait++;
               if (m_wait == 63) begin m_data = 10'h3FF; m_err = 1'b1; m_stage = 2; end
             end
`endif
          default: if (m_port ? rsp1_ready : rsp0_ready) begin
               m_last = m_port; m_busy = 1'b0;
             end
        endcase
      end
    end
  end

  task automatic next();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Counts negedges until the port's rsp_valid is seen; an expired bound is a failure.
  task automatic wait_rsp(input bit port, input int lim, output int n);
    n = 0;
    while (n < lim) begin
      @(negedge CLOCK_50);
      n++;
      if ((port ? rsp1_valid : rsp0_valid) === 1'b1) break;
    end
    if ((port ? rsp1_valid : rsp0_valid) !== 1'b1) check("wait_rsp_bound", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g[$];

    // Reset state, with a request pending that must not be acknowledged.
    req0_valid = 1'b1; req0_x = 10'h080; stub_val = 10'h057; stub_lat = 1;
    repeat (2) next();
    @(negedge CLOCK_50);
    check("rst_req0_ready", 64'(req0_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_exp_x", 64'(exp_x), 64'h000);
    check("rst_err", 64'(err), 64'd0);

    // Basic transaction, minimum latency.
    next(); reset = 1'b0;
    @(negedge CLOCK_50);
    check("basic_req0_ready", 64'(req0_ready), 64'd1);
    next(); req0_valid = 1'b0;
    wait_rsp(1'b0, 20, n);
    check("basic_latency", 64'(n), 64'd3);
    check("basic_rsp0_data", 64'(rsp0_data), 64'h057);
    check("basic_exp_x", 64'(exp_x), 64'h080);
    next(); rsp0_ready = 1'b1;
    next(); rsp0_ready = 1'b0;

    // Ties from reset alternate 0,1,0,1.
    reset = 1'b1;
    next();
    reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = 10'h3C0; req1_x = 10'h021; stub_val = 10'h0AA;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 60 && g.size() < 4; i++) begin
      @(negedge CLOCK_50);
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
    end
    next(); req0_valid = 1'b0; req1_valid = 1'b0;
    check("tie_count", 64'(g.size()), 64'd4);
    while (g.size() < 4) g.push_back(9);
    check("tie_0", 64'(g[0]), 64'd0);
    check("tie_1", 64'(g[1]), 64'd1);
    check("tie_2", 64'(g[2]), 64'd0);
    check("tie_3", 64'(g[3]), 64'd1);
    repeat (6) next();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    next();

    // Held response with competing request and a stray exp_done in RESP.
    req0_valid = 1'b1; req1_valid = 1'b1; req0_x = 10'h1A3; req1_x = 10'h2F0; stub_val = 10'h2C1;
    @(negedge CLOCK_50);
    check("hold_req0_ready", 64'(req0_ready), 64'd1);
    next(); req0_valid = 1'b0;
    wait_rsp(1'b0, 20, n);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) spur = 1'b1;
      @(negedge CLOCK_50);
      check("hold_rsp0", 64'({rsp0_valid, rsp0_data, busy, req1_ready}), 64'({1'b1, 10'h2C1, 1'b1, 1'b0}));
    end
    next(); rsp0_ready = 1'b1;
    next(); rsp0_ready = 1'b0;
    @(negedge CLOCK_50);
    check("hold_req1_next", 64'(req1_ready), 64'd1);
    next(); req1_valid = 1'b0;
    wait_rsp(1'b1, 20, n);
    check("hold_rsp1_data", 64'(rsp1_data), 64'h2C1);
    next(); rsp1_ready = 1'b1;
    next(); rsp1_ready = 1'b0;
    @(negedge CLOCK_50);
    spur = 1'b1;
    repeat (2) next();
    @(negedge CLOCK_50);
    check("idle_spur", 64'({busy, rsp0_valid, rsp1_valid, exp_x}), 64'({1'b0, 1'b0, 1'b0, 10'h2F0}));

    // Reset in WAIT, late exp_done afterwards.
    next();
    stub_lat = 3; stub_val = 10'h0F0; req0_x = 10'h2AA; req0_valid = 1'b1;
    @(negedge CLOCK_50);
    check("rw_req0_ready", 64'(req0_ready), 64'd1);
    next(); req0_valid = 1'b0;
    next();
    #2 reset = 1'b1;
    #1 check("rw_async", 64'({busy, exp_x, exp_start}), 64'd0);
    next(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      check("rw_late_done", 64'({busy, rsp0_valid}), 64'd0);
    end

    // Exp unit that never answers.
    next();
    stub_lat = 0; req1_x = 10'h111; req1_valid = 1'b1;
    @(negedge CLOCK_50);
    check("to_req1_ready", 64'(req1_ready), 64'd1);
    next(); req1_valid = 1'b0;
`ifdef EXP_ARB_TIMEOUT_EN
    wait_rsp(1'b1, 100, n);
    check("to_latency", 64'(n), 64'd65);
    check("to_data", 64'(rsp1_data), 64'h3FF);
    check("to_err", 64'(err), 64'd1);
    next(); rsp1_ready = 1'b1;
    next(); rsp1_ready = 1'b0;
    @(negedge CLOCK_50);
    check("to_err_sticky", 64'({err, busy}), 64'({1'b1, 1'b0}));
`else
    repeat (100) next();
    @(negedge CLOCK_50);
    check("to_busy_held", 64'({busy, err, rsp1_valid}), 64'({1'b1, 1'b0, 1'b0}));
`endif
    next(); reset = 1'b1;
    @(negedge CLOCK_50);
    check("to_reset_clear", 64'({err, busy}), 64'd0);
    next(); reset = 1'b0;
    repeat (3) next();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
